// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle multiply/divide unit controller with HI/LO registers
//
// Accepts mult/multu/div/divu/mthi/mtlo from the E stage and holds the pipeline
// while a multiply or divide is in flight. Results land in HI/LO exactly
// MULT_CYCLES or DIV_CYCLES edges after the start edge.
//
// Optional build macro: MDU_DIV_ZERO_KEEP_EN
//   defined   - div/divu by zero still runs the full busy period but leaves HI/LO untouched
//   undefined - div/divu by zero writes HI=A, LO=0xFFFFFFFF
//
// Ports:
//   clk     - clock, rising-edge
//   reset   - asynchronous active-high reset
//   start   - issue strobe qualifying md_op
//   md_op   - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
//   A, B    - operands (GRF[rs], GRF[rt]), sampled only on the accepted start edge
//   md_use  - D-stage instruction needs the MDU
//   busy    - multiply/divide in progress
//   stall   - pipeline stall request (combinational)
//   HI, LO  - architectural HI/LO registers

module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = ($clog2(MAX_CYCLES) < 4) ? 4 : $clog2(MAX_CYCLES);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [31:0]     a_q;
    logic [31:0]     b_q;
    logic            sgn_q;
    logic [31:0]     hi_q;
    logic [31:0]     lo_q;

    // Multiply: extend per signedness, then the low 64 bits of the 64x64
    // product are the exact 32x32 result in both signed and unsigned cases.
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;

    // Divide on magnitudes so the 0x80000000 / -1 overflow case falls out
    // naturally (magnitude 0x80000000 negated wraps back to itself).
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_div;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        b_zero;

    always_comb begin
        a_ext  = sgn_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
        b_ext  = sgn_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
        prod   = a_ext * b_ext;

        a_neg  = sgn_q & a_q[31];
        b_neg  = sgn_q & b_q[31];
        a_mag  = a_neg ? (~a_q + 32'd1) : a_q;
        b_mag  = b_neg ? (~b_q + 32'd1) : b_q;
        b_zero = (b_q == 32'd0);
        // Divisor of zero is replaced so the divider never sees /0; the
        // quotient/remainder are discarded in that case anyway.
        b_div  = b_zero ? 32'd1 : b_mag;
        q_mag  = a_mag / b_div;
        r_mag  = a_mag % b_div;
        quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem    = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        case (md_op)
                            OP_MULT, OP_MULTU: begin
                                a_q   <= A;
                                b_q   <= B;
                                sgn_q <= (md_op == OP_MULT);
                                cnt   <= MULT_LOAD;
                                busy  <= 1'b1;
                                state <= MULT;
                            end
                            OP_DIV, OP_DIVU: begin
                                a_q   <= A;
                                b_q   <= B;
                                sgn_q <= (md_op == OP_DIV);
                                cnt   <= DIV_LOAD;
                                busy  <= 1'b1;
                                state <= DIV;
                            end
                            OP_MTHI: hi_q <= A;
                            OP_MTLO: lo_q <= A;
                            default: ;
                        endcase
                    end
                end
                MULT: begin
                    if (cnt == '0) begin
                        hi_q  <= prod[63:32];
                        lo_q  <= prod[31:0];
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DIV: begin
                    if (cnt == '0) begin
                        if (b_zero) begin
`ifdef MDU_DIV_ZERO_KEEP_EN
                            hi_q <= hi_q;
                            lo_q <= lo_q;
`else
                            hi_q <= a_q;
                            lo_q <= 32'hFFFF_FFFF;
`endif
                        end else begin
                            hi_q <= rem;
                            lo_q <= quot;
                        end
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign stall = md_use & (busy | (start & (md_op >= OP_MULT) & (md_op <= OP_DIVU)));
    assign HI    = hi_q;
    assign LO    = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - directed self-checking bench for mdu_ctrl

module tb_mdu_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        md_use;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int ncyc;

    mdu_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .A     (A),
        .B     (B),
        .md_use(md_use),
        .busy  (busy),
        .stall (stall),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a start for one cycle, then scramble the operands so any late
    // sampling of A/B shows up in the result.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = op;
        A     = a;
        B     = b;
        #1;
        if (md_use && op >= 3'd1 && op <= 3'd4) chk("stall_start", {31'd0, stall}, 32'd1);
        tick();
        start = 1'b0;
        md_op = 3'd0;
        A     = $urandom;
        B     = $urandom;
    endtask

    // Count remaining busy cycles, bounded so a stuck busy cannot hang the run.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (md_use) chk("stall_busy", {31'd0, stall}, 32'd1);
            tick();
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        md_op  = 3'd0;
        A      = 32'd0;
        B      = 32'd0;
        md_use = 1'b0;
        #2;
        chk("rst_hi",    HI, 32'd0);
        chk("rst_lo",    LO, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        tick();
        tick();
        reset = 1'b0;

        // mult -2 * 3, issued on the first edge after reset release
        md_use = 1'b1;
        issue(3'd1, 32'hFFFF_FFFE, 32'd3);
        chk("mult_hi_hold", HI, 32'd0);
        wait_idle(ncyc);
        chk("mult_busy_len", ncyc, 32'd5);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFA);
        chk("mult_stall_done", {31'd0, stall}, 32'd0);

        // multu 0xFFFFFFFF * 2, no stall without md_use
        md_use = 1'b0;
        start  = 1'b1;
        md_op  = 3'd2;
        A      = 32'hFFFF_FFFF;
        B      = 32'd2;
        #1;
        chk("multu_nouse_stall", {31'd0, stall}, 32'd0);
        tick();
        start = 1'b0;
        md_op = 3'd0;
        A     = 32'h0;
        B     = 32'h0;
        wait_idle(ncyc);
        chk("multu_busy_len", ncyc, 32'd5);
        chk("multu_hi", HI, 32'h0000_0001);
        chk("multu_lo", LO, 32'hFFFF_FFFE);

        // div -7 / 2 with a second div start at T+3 that must be ignored
        md_use = 1'b1;
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        tick();
        tick();
        start = 1'b1;
        md_op = 3'd3;
        A     = 32'd100;
        B     = 32'd1;
        tick();
        start = 1'b0;
        md_op = 3'd0;
        wait_idle(ncyc);
        chk("div_busy_rest", ncyc, 32'd7);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        chk("div_hi", HI, 32'hFFFF_FFFF);
        chk("div_stall_done", {31'd0, stall}, 32'd0);

        // reset pulse at T+4 of a div aborts it
        md_use = 1'b0;
        issue(3'd3, 32'd100, 32'd3);
        tick();
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("arst_hi",   HI, 32'd0);
        chk("arst_lo",   LO, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        repeat (8) tick();
        chk("arst_hi_after",   HI, 32'd0);
        chk("arst_lo_after",   LO, 32'd0);
        chk("arst_busy_after", {31'd0, busy}, 32'd0);

        // mthi / mtlo write immediately without a busy period
        issue(3'd5, 32'h0000_AAAA, 32'd0);
        chk("mthi_hi",   HI, 32'h0000_AAAA);
        chk("mthi_busy", {31'd0, busy}, 32'd0);
        issue(3'd6, 32'h0000_5555, 32'd0);
        chk("mtlo_lo",   LO, 32'h0000_5555);
        chk("mtlo_hi",   HI, 32'h0000_AAAA);

        // divu 5 / 0
        issue(3'd4, 32'd5, 32'd0);
        wait_idle(ncyc);
        chk("div0_busy_len", ncyc, 32'd10);
`ifdef MDU_DIV_ZERO_KEEP_EN
        chk("div0_hi", HI, 32'h0000_AAAA);
        chk("div0_lo", LO, 32'h0000_5555);
`else
        chk("div0_hi", HI, 32'd5);
        chk("div0_lo", LO, 32'hFFFF_FFFF);
`endif
        issue(3'd6, 32'h0000_1234, 32'd0);
        chk("mtlo2_lo",   LO, 32'h0000_1234);
        chk("mtlo2_busy", {31'd0, busy}, 32'd0);

        // reserved and none opcodes are ignored
        issue(3'd7, 32'hDEAD_BEEF, 32'd1);
        chk("op7_busy", {31'd0, busy}, 32'd0);
        chk("op7_lo",   LO, 32'h0000_1234);
        issue(3'd0, 32'hDEAD_BEEF, 32'd1);
        chk("op0_busy", {31'd0, busy}, 32'd0);
        chk("op0_lo",   LO, 32'h0000_1234);

        // div overflow case
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(ncyc);
        chk("ovf_lo", LO, 32'h8000_0000);
        chk("ovf_hi", HI, 32'h0000_0000);

        // div 7 / -2: quotient truncates toward zero, remainder follows A
        issue(3'd3, 32'd7, 32'hFFFF_FFFE);
        wait_idle(ncyc);
        chk("negb_lo", LO, 32'hFFFF_FFFD);
        chk("negb_hi", HI, 32'h0000_0001);

        // divu with top bit set treated as unsigned
        issue(3'd4, 32'hFFFF_FFFF, 32'd16);
        wait_idle(ncyc);
        chk("divu_lo", LO, 32'h0FFF_FFFF);
        chk("divu_hi", HI, 32'h0000_000F);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
